seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath.sv | 192 +++++++++++++++++++
 tb/tb_seq_datapath.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath.sv
// Multi-cycle accumulator-free datapath: fetch/exec/mem/writeback over a single memory port.
// Instructions carry a 5-bit opcode, three register fields and a sign-extended constant.
module seq_datapath #(
    parameter int unsigned W      = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      mem_wdata,
    input  logic [W-1:0]      mem_rdata,
    input  logic              mem_ready,
    input  logic [W-1:0]      in_port,
    output logic [W-1:0]      out_port,
    output logic              out_valid,
    output logic              halted
);

    localparam int unsigned RB = $clog2(NREGS);
    localparam int unsigned CW = W - 5 - 2 * RB;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpBrz  = 5'b10010;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [W-1:0]      ir_q, ir_d;
    logic [W-1:0]      rz_q, rz_d;
    logic [W-1:0]      out_port_q, out_port_d;
    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      regs_q [NREGS];
    logic              rf_we;

    logic [4:0]    op;
    logic [RB-1:0] ra_idx, rb_idx, rc_idx;
    logic [W-1:0]  imm, ra_val, rb_val, rc_val;

    // rc occupies the top bits of the constant field; each opcode uses only one of them.
    assign op     = ir_q[W-1 -: 5];
    assign ra_idx = ir_q[W-6 -: RB];
    assign rb_idx = ir_q[W-6-RB -: RB];
    assign rc_idx = ir_q[CW-1 -: RB];
    assign imm    = {{(W - CW){ir_q[CW-1]}}, ir_q[CW-1:0]};

    assign ra_val = (ra_idx == '0) ? '0 : regs_q[ra_idx];
    assign rb_val = (rb_idx == '0) ? '0 : regs_q[rb_idx];
    assign rc_val = (rc_idx == '0) ? '0 : regs_q[rc_idx];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        rz_d        = rz_q;
        out_port_d  = out_port_q;
        out_valid_d = 1'b0;
        rf_we       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OpLd, OpSt: state_d = StMem;
                    OpAdd: begin
                        rz_d    = rb_val + rc_val;
                        state_d = StWb;
                    end
                    OpSub: begin
                        rz_d    = rb_val - rc_val;
                        state_d = StWb;
                    end
                    OpAnd: begin
                        rz_d    = rb_val & rc_val;
                        state_d = StWb;
                    end
                    OpOr: begin
                        rz_d    = rb_val | rc_val;
                        state_d = StWb;
                    end
                    OpAddi: begin
                        rz_d    = rb_val + imm;
                        state_d = StWb;
                    end
                    OpIn: begin
                        rz_d    = in_port;
                        state_d = StWb;
                    end
                    OpBrz: begin
                        // pc_q already points past the branch.
                        if (ra_val == '0) begin
                            pc_d = pc_q + imm[ADDR_W-1:0];
                        end
                    end
                    OpOut: begin
                        out_port_d  = ra_val;
                        out_valid_d = 1'b1;
                    end
                    OpHalt:  state_d = StHalt;
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                mem_req   = 1'b1;
                mem_we    = (op == OpSt);
                mem_addr  = ADDR_W'(rb_val + imm);
                mem_wdata = ra_val;
                if (mem_ready) begin
                    if (op == OpSt) begin
                        state_d = StFetch;
                    end else begin
                        rz_d    = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            ir_q        <= '0;
            rz_q        <= '0;
            out_port_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rz_q        <= rz_d;
            out_port_q  <= out_port_d;
            out_valid_q <= out_valid_d;
            if (rf_we && (ra_idx != '0)) begin
                regs_q[ra_idx] <= rz_q;
            end
        end
    end

    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: small programs in a modelled memory, outputs checked via a scoreboard.
// A second instance covers the narrow W=16 / NREGS=4 / ADDR_W=6 configuration.
module tb_seq_datapath;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpNop  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpBrz  = 5'b10010;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpHalt = 5'b11011;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear, run, mem_req, mem_we, mem_ready, out_valid, halted;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, in_port, out_port;

    logic        clear16, run16, req16, we16, ready16, ov16, halted16;
    logic [5:0]  addr16;
    logic [15:0] wdata16, rdata16, in16, out16;

    seq_datapath #(.W(32), .NREGS(16), .ADDR_W(9)) dut (
        .clock(clock), .clear(clear), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .in_port(in_port), .out_port(out_port), .out_valid(out_valid), .halted(halted)
    );

    seq_datapath #(.W(16), .NREGS(4), .ADDR_W(6)) dut16 (
        .clock(clock), .clear(clear16), .run(run16),
        .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(ready16),
        .in_port(in16), .out_port(out16), .out_valid(ov16), .halted(halted16)
    );

    logic [31:0] mem   [512];
    logic [15:0] mem16 [64];
    logic        ld_we, ld_sel, wipe, stall_writes;
    logic [8:0]  ld_addr;
    logic [31:0] ld_data;
    int          wait_n;
    int          wcnt = 0;

    assign mem_rdata = mem[mem_addr];
    assign rdata16   = mem16[addr16];
    assign ready16   = 1'b1;
    assign mem_ready = mem_req && !(stall_writes && mem_we) && (wcnt >= wait_n);

    always @(posedge clock) begin
        if (wipe) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            for (int i = 0; i < 64; i++) mem16[i] <= 16'h0;
        end else if (ld_we) begin
            if (ld_sel) mem16[ld_addr[5:0]] <= ld_data[15:0];
            else        mem[ld_addr] <= ld_data;
        end else begin
            if (mem_req && mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
            if (req16 && we16 && ready16) mem16[addr16] <= wdata16;
        end
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                       wcnt <= 0;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Scoreboard and bus monitors, sampled on the falling edge.
    logic [31:0] exp_q[$];
    logic [31:0] exp16_q[$];
    logic [8:0]  rd_log[$];
    int          extra_cnt = 0;
    logic        prev_stall = 1'b0;
    logic        prev_we;
    logic [8:0]  prev_addr;
    logic [31:0] prev_wdata;

    always @(negedge clock) begin
        if (out_valid) begin
            if (exp_q.size() > 0) check_eq("out_port", out_port, exp_q.pop_front());
            else extra_cnt <= extra_cnt + 1;
        end
        if (ov16) begin
            if (exp16_q.size() > 0) check_eq("out16", {16'h0, out16}, exp16_q.pop_front());
            else extra_cnt <= extra_cnt + 1;
        end
        if (mem_req && mem_ready && !mem_we) rd_log.push_back(mem_addr);
        if (prev_stall && mem_req) begin
            check_eq("hold_addr", 32'(mem_addr), 32'(prev_addr));
            check_eq("hold_we", 32'(mem_we), 32'(prev_we));
            check_eq("hold_wdata", mem_wdata, prev_wdata);
        end
        prev_stall <= mem_req && !mem_ready;
        prev_addr  <= mem_addr;
        prev_we    <= mem_we;
        prev_wdata <= mem_wdata;
    end

    logic [31:0] prog[$];

    function automatic logic [31:0] enc(input logic [4:0] op, input int ra, input int rb,
                                        input int rc, input int c);
        logic [31:0] w;
        w = {op, 4'(ra), 4'(rb), 19'(c)};
        w[18:15] = w[18:15] | 4'(rc);
        return w;
    endfunction

    function automatic logic [31:0] enc16(input logic [4:0] op, input int ra, input int rb,
                                          input int rc, input int c);
        logic [15:0] w;
        w = {op, 2'(ra), 2'(rb), 7'(c)};
        w[6:5] = w[6:5] | 2'(rc);
        return {16'h0, w};
    endfunction

    task automatic load_word(input logic sel, input int a, input logic [31:0] d);
        ld_sel  = sel;
        ld_addr = 9'(a);
        ld_data = d;
        ld_we   = 1'b1;
        @(posedge clock);
        #1;
        ld_we = 1'b0;
    endtask

    task automatic load_prog(input logic sel);
        for (int i = 0; i < prog.size(); i++) load_word(sel, i, prog[i]);
    endtask

    task automatic fresh();
        clear = 1'b1;
        wipe  = 1'b1;
        @(posedge clock);
        #1;
        wipe  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic run_prog(input int max, output int cycles);
        run    = 1'b1;
        cycles = 0;
        do begin
            @(posedge clock);
            #1;
            cycles++;
            run = 1'b0;
        end while (!halted && cycles < max);
    endtask

    task automatic end_prog(input string tag);
        check_eq({tag, "_halted"}, 32'(halted), 1);
        check_eq({tag, "_missing_out"}, 32'(exp_q.size()), 0);
        check_eq({tag, "_extra_out"}, 32'(extra_cnt), 0);
    endtask

    int cyc;
    int n;
    int rd_start;

    initial begin
        clear = 1'b1; clear16 = 1'b1; run = 1'b0; run16 = 1'b0;
        in_port = 32'h0; in16 = 16'h0;
        ld_we = 1'b0; ld_sel = 1'b0; ld_addr = 9'h0; ld_data = 32'h0;
        wipe = 1'b0; wait_n = 0; stall_writes = 1'b0;
        fresh();

        check_eq("rst_mem_req", 32'(mem_req), 0);
        check_eq("rst_mem_we", 32'(mem_we), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_out_port", out_port, 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_halted", 32'(halted), 0);

        run = 1'b1; clear = 1'b1;
        @(posedge clock);
        #1;
        check_eq("clear_over_run", 32'(mem_req), 0);
        run = 1'b0; clear = 1'b0;

        // Basic program: 5 + (-3) = 2, halts 14 cycles after run.
        prog = {enc(OpAddi, 1, 0, 0, 5), enc(OpAddi, 2, 0, 0, -3), enc(OpAdd, 3, 1, 2, 0),
                enc(OpOut, 3, 0, 0, 0), enc(OpHalt, 0, 0, 0, 0)};
        load_prog(1'b0);
        exp_q.push_back(32'd2);
        run_prog(100, cyc);
        check_eq("prog_a_cycles", cyc, 14);
        @(posedge clock);
        #1;
        check_eq("halt_absorbing", 32'(halted), 1);
        check_eq("halt_no_req", 32'(mem_req), 0);
        end_prog("prog_a");

        // IN, ST/LD with address wrap, r0, SUB/AND/OR, unassigned opcode as NOP.
        fresh();
        in_port = 32'hDEADBEEF;
        prog = {enc(OpIn, 5, 0, 0, 0), enc(OpAddi, 2, 0, 0, 511), enc(OpSt, 5, 2, 0, 1),
                enc(OpLd, 6, 2, 0, 1), enc(OpOut, 6, 0, 0, 0), enc(OpAddi, 0, 0, 0, 5),
                enc(OpOut, 0, 0, 0, 0), enc(OpAddi, 7, 0, 0, 12), enc(OpAddi, 8, 0, 0, 10),
                enc(OpSub, 9, 8, 7, 0), enc(OpOut, 9, 0, 0, 0), enc(OpAnd, 10, 7, 8, 0),
                enc(OpOr, 11, 7, 8, 0), enc(OpOut, 10, 0, 0, 0), enc(OpOut, 11, 0, 0, 0),
                enc(OpNop, 12, 7, 8, 0), enc(OpOut, 12, 0, 0, 0), enc(OpHalt, 0, 0, 0, 0)};
        load_prog(1'b0);
        exp_q = {32'hDEADBEEF, 32'h0, 32'hFFFFFFFE, 32'h8, 32'hE, 32'h0};
        run_prog(200, cyc);
        check_eq("prog_b_cycles", cyc, 48);
        check_eq("st_wrap_mem0", mem[0], 32'hDEADBEEF);
        check_eq("st_no_mem511", mem[511], 32'h0);
        end_prog("prog_b");

        // Three wait cycles on every transaction.
        fresh();
        prog = {enc(OpLd, 1, 0, 0, 8), enc(OpSt, 1, 0, 0, 9), enc(OpOut, 1, 0, 0, 0),
                enc(OpHalt, 0, 0, 0, 0)};
        load_prog(1'b0);
        load_word(1'b0, 8, 32'h12345678);
        wait_n = 3;
        exp_q.push_back(32'h12345678);
        run_prog(200, cyc);
        check_eq("wait_cycles", cyc, 1 + (4 + 6) + (3 + 6) + (2 + 3) + (2 + 3));
        check_eq("wait_st_data", mem[9], 32'h12345678);
        end_prog("prog_wait");
        wait_n = 0;

        // BRZ: taken forward, taken backward to 4, then not taken to 6.
        fresh();
        prog = {enc(OpAddi, 1, 0, 0, 7), enc(OpBrz, 0, 0, 0, 3), enc(OpOut, 0, 0, 0, 0),
                enc(OpHalt, 0, 0, 0, 0), enc(OpAddi, 2, 0, 0, 7), enc(OpBrz, 2, 0, 0, -2),
                enc(OpOut, 2, 0, 0, 0), enc(OpHalt, 0, 0, 0, 0)};
        load_prog(1'b0);
        exp_q.push_back(32'd7);
        rd_start = rd_log.size();
        run_prog(100, cyc);
        check_eq("brz_cycles", cyc, 17);
        check_eq("brz_nfetch", 32'(rd_log.size() - rd_start), 7);
        prog = {32'd0, 32'd1, 32'd5, 32'd4, 32'd5, 32'd6, 32'd7};
        for (int i = 0; i < 7; i++) begin
            if (rd_start + i < rd_log.size())
                check_eq($sformatf("brz_fetch%0d", i), 32'(rd_log[rd_start + i]), prog[i]);
        end
        end_prog("prog_brz");

        // Clear while a store is stalled in MEM.
        fresh();
        stall_writes = 1'b1;
        prog = {enc(OpAddi, 1, 0, 0, 9), enc(OpSt, 1, 0, 0, 20), enc(OpHalt, 0, 0, 0, 0)};
        load_prog(1'b0);
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("st_stall_seen", 32'(mem_req && mem_we), 1);
        check_eq("st_stall_addr", 32'(mem_addr), 20);
        check_eq("st_stall_wdata", mem_wdata, 9);
        repeat (2) @(posedge clock);
        #1;
        check_eq("st_still_req", 32'(mem_req), 1);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check_eq("abort_req", 32'(mem_req), 0);
        check_eq("abort_halted", 32'(halted), 0);
        check_eq("abort_addr", 32'(mem_addr), 0);
        stall_writes = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("abort_idle", 32'(mem_req), 0);
        check_eq("abort_no_st", mem[20], 32'h0);
        run = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b0;
        check_eq("restart_req", 32'(mem_req), 1);
        check_eq("restart_pc", 32'(mem_addr), 0);
        check_eq("restart_we", 32'(mem_we), 0);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;

        // Narrow configuration: 0xFFFF + 1 wraps to 0, ADDI with C = -1.
        in16 = 16'hFFFF;
        prog = {enc16(OpIn, 1, 0, 0, 0), enc16(OpAddi, 2, 0, 0, 1), enc16(OpAdd, 3, 1, 2, 0),
                enc16(OpOut, 3, 0, 0, 0), enc16(OpAddi, 3, 1, 0, -1), enc16(OpOut, 3, 0, 0, 0),
                enc16(OpHalt, 0, 0, 0, 0)};
        load_prog(1'b1);
        clear16 = 1'b1;
        @(posedge clock);
        #1;
        clear16 = 1'b0;
        check_eq("rst16_halted", 32'(halted16), 0);
        exp16_q = {32'h0000, 32'hFFFE};
        run16 = 1'b1;
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
            run16 = 1'b0;
        end while (!halted16 && cyc < 100);
        check_eq("p16_cycles", cyc, 19);
        check_eq("p16_halted", 32'(halted16), 1);
        check_eq("p16_missing_out", 32'(exp16_q.size()), 0);
        check_eq("extra_out_final", 32'(extra_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
